instr_stream_encoder: RTL and testbench

Sequential RV32I instruction encoder and loader for the pipeline test harness. Accepts field-level instruction descriptions over a valid/ready handshake and assembles each into a 32-bit word. Writes the words into instruction memory at consecutive word addresses. It produces exactly the opcodes the main control decoder consumes (51, 3, 19, 35, 111, 99, 55, 103), so the decoder's input side can be driven from a structured program description.

---
 rtl/rv_isa_pkg.sv | 47 ++++
 rtl/rv_field_packer.sv | 53 +++++
 rtl/instr_stream_encoder.sv | 117 +++++++++++
 tb/tb_instr_stream_encoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// RV32I opcodes, descriptor format codes and loader FSM states shared by the encoder and control decoder.
// Pure definitions: no latency, no flow control.
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_JALR   = 7'd103;

  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_IMM    = 3'd1;
  localparam logic [2:0] FMT_LOAD   = 3'd2;
  localparam logic [2:0] FMT_STORE  = 3'd3;
  localparam logic [2:0] FMT_BRANCH = 3'd4;
  localparam logic [2:0] FMT_JAL    = 3'd5;
  localparam logic [2:0] FMT_LUI    = 3'd6;
  localparam logic [2:0] FMT_JALR   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE
  } enc_state_t;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } desc_t;

  // True when v survives truncation to n bits and sign-extension back.
  function automatic logic fits_signed(input logic [31:0] v, input int n);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (n - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/rv_field_packer.sv
// Packs one descriptor into an RV32I word and flags an immediate that does not fit its field.
// Combinational, zero latency; no flow control.
module rv_field_packer
  import rv_isa_pkg::*;
(
  input  desc_t       desc,
  output logic [31:0] word,
  output logic        range_err
);

  logic [31:0] imm;
  assign imm = desc.imm;

  always_comb begin
    word      = '0;
    range_err = 1'b0;
    case (desc.fmt)
      FMT_R: word = {desc.f7, desc.rs2, desc.rs1, desc.f3, desc.rd, OP_R};
      FMT_IMM: begin
        word = {imm[11:0], desc.rs1, desc.f3, desc.rd, OP_IMM};
        // Shift-immediates carry funct7 in the top of the immediate field.
        if (desc.f3 == 3'b001 || desc.f3 == 3'b101) word[31:25] = desc.f7;
        range_err = !fits_signed(imm, 12);
      end
      FMT_LOAD: begin
        word      = {imm[11:0], desc.rs1, desc.f3, desc.rd, OP_LOAD};
        range_err = !fits_signed(imm, 12);
      end
      FMT_JALR: begin
        word      = {imm[11:0], desc.rs1, 3'b000, desc.rd, OP_JALR};
        range_err = !fits_signed(imm, 12);
      end
      FMT_STORE: begin
        word      = {imm[11:5], desc.rs2, desc.rs1, desc.f3, imm[4:0], OP_STORE};
        range_err = !fits_signed(imm, 12);
      end
      FMT_BRANCH: begin
        word      = {imm[12], imm[10:5], desc.rs2, desc.rs1, desc.f3, imm[4:1], imm[11], OP_BRANCH};
        range_err = !fits_signed(imm, 13) || imm[0];
      end
      FMT_JAL: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], desc.rd, OP_JAL};
        range_err = !fits_signed(imm, 21) || imm[0];
      end
      FMT_LUI: begin
        word      = {imm[31:12], desc.rd, OP_LUI};
        range_err = (imm[11:0] != 12'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Accepts instruction descriptors, encodes them and writes them to consecutive instruction-memory words.
// One cycle from handshake to mem_we; in_ready only in ACCEPT, so at most one word every 2 cycles.
module instr_stream_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_f3,
  input  logic [6:0]        in_f7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  enc_state_t        state_q, state_d;
  desc_t             desc;
  logic [31:0]       enc_word, word_q;
  logic              enc_err, rerr_q, last_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic              at_top, clr;

  assign desc = '{fmt: in_fmt, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                  f3: in_f3, f7: in_f7, imm: in_imm};

  rv_field_packer u_packer (
    .desc      (desc),
    .word      (enc_word),
    .range_err (enc_err)
  );

  assign at_top = (ptr_q == PTR_MAX);
  assign clr    = start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ACCEPT;
      ST_ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we  = 1'b1;
        busy    = 1'b1;
        state_d = (last_q || at_top) ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_ACCEPT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      rerr_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (clr) begin
        ptr_q   <= '0;
        count_q <= '0;
        err_q   <= 1'b0;
      end
      if (in_valid && in_ready) begin
        word_q <= enc_word;
        rerr_q <= enc_err;
        last_q <= in_last;
      end
      if (mem_we) begin
        count_q <= count_q + 1'b1;
        // The pointer parks on the last word rather than wrapping.
        if (!at_top) ptr_q <= ptr_q + 1'b1;
        if (rerr_q || (at_top && !last_q)) err_q <= 1'b1;
      end
    end
  end

  assign mem_addr  = ptr_q;
  assign mem_wdata = word_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: directed program loads, a randomized load against an encoding model,
// reset during a write, and pointer overflow on a 4-word instance.
module tb_instr_stream_encoder;
  import rv_isa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [2:0]  in_fmt = '0, in_f3 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [6:0]  in_f7 = '0;
  logic [31:0] in_imm = '0;
  logic        in_ready, mem_we, busy, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] count;

  instr_stream_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_f3(in_f3),
    .in_f7(in_f7), .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .count(count), .err(err)
  );

  logic        s_reset = 1'b0, s_start = 1'b0, s_valid = 1'b0;
  logic        s_ready, s_we, s_busy, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  instr_stream_encoder #(.ADDR_W(2)) dut_s (
    .clk(clk), .reset(s_reset), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_f3(in_f3),
    .in_f7(in_f7), .in_imm(in_imm), .in_last(in_last), .mem_we(s_we), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .busy(s_busy), .done(s_done), .count(s_count), .err(s_err)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference encoder: places each field by shift/mask; range rules via signed integer bounds.
  function automatic logic [32:0] ref_encode(input logic [2:0] fmt, input logic [4:0] rd, rs1, rs2,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [31:0] imm);
    logic [31:0] w, d, a, b, f, s;
    int          si;
    logic        e;
    d = 32'(rd) << 7;  a = 32'(rs1) << 15;  b = 32'(rs2) << 20;  f = 32'(f3) << 12;
    s = 32'(f7) << 25; si = $signed(imm);   e = 1'b0;  w = '0;
    case (fmt)
      3'd0: w = s | b | a | f | d | 32'd51;
      3'd1: begin
        w = ((imm & 32'hfff) << 20) | a | f | d | 32'd19;
        if (f3 == 3'd1 || f3 == 3'd5) w = (w & 32'h01ff_ffff) | s;
        e = si < -2048 || si > 2047;
      end
      3'd2: begin w = ((imm & 32'hfff) << 20) | a | f | d | 32'd3;   e = si < -2048 || si > 2047; end
      3'd7: begin w = ((imm & 32'hfff) << 20) | a | d | 32'd103;     e = si < -2048 || si > 2047; end
      3'd3: begin
        w = (((imm >> 5) & 32'h7f) << 25) | b | a | f | ((imm & 32'h1f) << 7) | 32'd35;
        e = si < -2048 || si > 2047;
      end
      3'd4: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | b | a | f
          | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | 32'd99;
        e = si < -4096 || si > 4095 || imm[0];
      end
      3'd5: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 1) << 20)
          | (((imm >> 12) & 32'hff) << 12) | d | 32'd111;
        e = si < -(1 << 20) || si > (1 << 20) - 1 || imm[0];
      end
      default: begin w = (imm & 32'hffff_f000) | d | 32'd55; e = (imm & 32'hfff) != 0; end
    endcase
    return {e, w};
  endfunction

  typedef struct {int addr; logic [31:0] word; int cnt;} exp_t;
  exp_t        exp_q[$];
  int          m_ptr = 0, m_cnt = 0;
  logic        m_err = 1'b0;
  logic [31:0] wr_log [0:1023];
  int          wr_total = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      exp_t ex;
      chk("we_single", 32'(prev_we), 0);
      chk("ready_in_write", 32'(in_ready), 0);
      chk("busy_in_write", 32'(busy), 1);
      if (exp_q.size() == 0) chk("we_unexpected", 1, 0);
      else begin
        ex = exp_q.pop_front();
        chk("addr", 32'(mem_addr), 32'(ex.addr));
        chk("wdata", mem_wdata, ex.word);
        chk("count_at_write", 32'(count), 32'(ex.cnt));
      end
      wr_log[mem_addr] = mem_wdata;
      wr_total++;
    end
    prev_we = mem_we;
  end

  int          s_writes = 0;
  logic [1:0]  s_last_addr = '0;
  logic [31:0] s_last_wdata = '0;
  always @(negedge clk) begin
    if (s_we) begin
      s_writes++;
      s_last_addr  = s_addr;
      s_last_wdata = s_wdata;
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    chk("start_ready", 32'(in_ready), 1);
    chk("start_count", 32'(count), 0);
    chk("start_err", 32'(err), 0);
  endtask

  task automatic send(input logic [2:0] fmt, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic last);
    logic [32:0] r;
    int          wt = 0;
    in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_f3 = f3; in_f7 = f7;
    in_imm = imm; in_last = last; in_valid = 1'b1;
    while (!in_ready && wt < 20) begin @(negedge clk); wt++; end
    if (!in_ready) begin
      chk("handshake_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    r = ref_encode(fmt, rd, rs1, rs2, f3, f7, imm);
    exp_q.push_back('{addr: m_ptr, word: r[31:0], cnt: m_cnt});
    m_err = m_err | r[32];
    m_cnt++;
    if (m_ptr == 1023 && !last) m_err = 1'b1;
    if (m_ptr != 1023) m_ptr++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int wt = 0;
    while (!done && wt < 20) begin @(negedge clk); wt++; end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_count"}, 32'(count), 32'(m_cnt));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_imm(input logic [2:0] fmt, input logic [2:0] f3);
    if ($urandom_range(0, 4) == 0) return $urandom();
    case (fmt)
      FMT_BRANCH: return 32'(2 * (int'($urandom_range(0, 4095)) - 2048));
      FMT_JAL:    return 32'(2 * (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)));
      FMT_LUI:    return $urandom() & 32'hffff_f000;
      FMT_IMM:    if (f3 == 3'd1 || f3 == 3'd5) return 32'($urandom_range(0, 31));
                  else return 32'(int'($urandom_range(0, 4095)) - 2048);
      default:    return 32'(int'($urandom_range(0, 4095)) - 2048);
    endcase
  endfunction

  initial begin
    int w0, s_refused;
    #1;
    chk("rst_ready", 32'(in_ready), 0);  chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);   chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", 32'(busy), 0);       chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);     chk("rst_err", 32'(err), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 0);

    do_start();
    send(FMT_R, 3, 1, 2, 0, 0, 0, 1);
    wait_done("add");
    chk("add_word", wr_log[0], 32'h002081B3);

    do_start();
    w0 = wr_total;
    send(FMT_IMM, 1, 0, 0, 0, 0, 5, 0);
    send(FMT_LOAD, 2, 1, 0, 3'b010, 0, 8, 1);
    wait_done("addi_lw");
    chk("addi_word", wr_log[0], 32'h00500093);
    chk("lw_word", wr_log[1], 32'h0080A103);
    chk("addi_lw_pulses", 32'(wr_total - w0), 2);

    do_start();
    send(FMT_STORE, 0, 1, 2, 3'b010, 0, 4, 0);
    send(FMT_BRANCH, 0, 1, 2, 3'b000, 0, -32'sd4, 1);
    wait_done("sw_beq");
    chk("sw_word", wr_log[0], 32'h0020A223);
    chk("beq_word", wr_log[1], 32'hFE208EE3);

    do_start();
    send(FMT_JAL, 1, 0, 0, 0, 0, 8, 0);
    send(FMT_LUI, 5, 0, 0, 0, 0, 32'h12345000, 1);
    wait_done("jal_lui");
    chk("jal_word", wr_log[0], 32'h008000EF);
    chk("lui_word", wr_log[1], 32'h123452B7);

    do_start();
    send(FMT_IMM, 1, 0, 0, 0, 0, 4096, 0);
    send(FMT_BRANCH, 0, 1, 2, 0, 0, 6, 0);
    send(FMT_R, 3, 1, 2, 0, 0, 0, 1);
    wait_done("range");
    chk("range_err_sticky", 32'(err), 1);
    chk("addi4096_word", wr_log[0], 32'h00000093);

    do_start();
    send(FMT_BRANCH, 0, 1, 2, 0, 0, 7, 1);
    wait_done("beq_odd");

    do_start();
    for (int i = 0; i < 40; i++) begin
      logic [2:0] fmt, f3;
      fmt = 3'($urandom());
      f3  = 3'($urandom());
      send(fmt, 5'($urandom()), 5'($urandom()), 5'($urandom()), f3, 7'($urandom()),
           rand_imm(fmt, f3), i == 39);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_done("random");

    do_start();
    send(FMT_IMM, 1, 0, 0, 0, 0, 5, 0);
    send(FMT_IMM, 2, 1, 0, 0, 0, 9, 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_we", 32'(mem_we), 0);    chk("midrst_ready", 32'(in_ready), 0);
    chk("midrst_busy", 32'(busy), 0);    chk("midrst_done", 32'(done), 0);
    chk("midrst_count", 32'(count), 0);  chk("midrst_err", 32'(err), 0);
    chk("midrst_addr", 32'(mem_addr), 0); chk("midrst_wdata", mem_wdata, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {30'd0, mem_we, in_ready}, 0);
    end

    s_reset = 1'b1;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_refused = 0;
    in_fmt = FMT_IMM; in_rd = 1; in_rs1 = 0; in_rs2 = 0; in_f3 = 0; in_f7 = 0;
    in_imm = 5; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int wt = 0;
      s_valid = 1'b1;
      while (!s_ready && wt < 6) begin @(negedge clk); wt++; end
      if (s_ready) begin
        @(posedge clk);
        @(negedge clk);
      end else s_refused++;
      s_valid = 1'b0;
    end
    @(negedge clk);
    chk("ovf_writes", 32'(s_writes), 4);
    chk("ovf_refused", 32'(s_refused), 1);
    chk("ovf_err", 32'(s_err), 1);
    chk("ovf_done", 32'(s_done), 1);
    chk("ovf_ready", 32'(s_ready), 0);
    chk("ovf_busy", 32'(s_busy), 0);
    chk("ovf_count", 32'(s_count), 4);
    chk("ovf_last_addr", 32'(s_last_addr), 3);
    chk("ovf_last_word", s_last_wdata, 32'h00500093);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
